guarded_counter_scrubber: RTL and testbench

Controller that sequences a guarded unsigned counter and periodically checks its integrity. It gates the counter's increment, keeps an independent shadow count, and every SCRUB_PERIOD increments pauses the counter to compare its value and even/odd guard bit counts against expected values. On mismatch it clears the counter, raises an interrupt and counts the error. After MAX_RETRY consecutive failures it locks into a fatal state. It sits between the counter instance and the host/status logic.

---
 rtl/guarded_counter_scrubber_pkg.sv | 39 +++
 rtl/guarded_counter_scrubber_if.sv | 34 +++
 rtl/guarded_counter_scrubber_guard_popcount.sv | 18 +
 rtl/guarded_counter_scrubber.sv | 155 +++++++++++++++
 tb/tb_guarded_counter_scrubber.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/guarded_counter_scrubber_pkg.sv
// Shared types and helpers for the guarded counter scrubber and its counter.
// Popcount helpers take the live width as an argument so one definition serves any WIDTH.
package guarded_counter_pkg;

  localparam int unsigned ERR_COUNT_W = 8;
  localparam int unsigned POP_MAX_W   = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_HOLD,
    ST_CHECK,
    ST_RECOVER,
    ST_FATAL
  } state_e;

  // Set bits at indices 0,2,4,... below width.
  function automatic int unsigned even_popcount(input logic [POP_MAX_W-1:0] value,
                                                input int unsigned width);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < POP_MAX_W; i += 2) begin
      if (i < width) n += 32'(value[i]);
    end
    return n;
  endfunction

  // Set bits at indices 1,3,5,... below width.
  function automatic int unsigned odd_popcount(input logic [POP_MAX_W-1:0] value,
                                               input int unsigned width);
    int unsigned n;
    n = 0;
    for (int unsigned i = 1; i < POP_MAX_W; i += 2) begin
      if (i < width) n += 32'(value[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/guarded_counter_scrubber_if.sv
// Counter-side and host-side signals of the scrubber, bundled for port connection.
interface guarded_counter_scrubber_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GUARD_BITS = 4
);
  import guarded_counter_pkg::*;

  logic                   start;
  logic                   stop;
  logic                   err_ack;
  logic [WIDTH-1:0]       cnt_value;
  logic [GUARD_BITS-1:0]  cnt_even;
  logic [GUARD_BITS-1:0]  cnt_odd;
  logic                   cnt_en;
  logic                   cnt_clr;
  logic [WIDTH-1:0]       shadow;
  logic                   busy;
  logic                   err_irq;
  logic [ERR_COUNT_W-1:0] err_count;
  logic                   fatal;

  // The scrubber itself.
  modport slave (
    input  start, stop, err_ack, cnt_value, cnt_even, cnt_odd,
    output cnt_en, cnt_clr, shadow, busy, err_irq, err_count, fatal
  );

  // Counter instance plus host/status logic.
  modport master (
    output start, stop, err_ack, cnt_value, cnt_even, cnt_odd,
    input  cnt_en, cnt_clr, shadow, busy, err_irq, err_count, fatal
  );

endinterface

// File: rtl/guarded_counter_scrubber_guard_popcount.sv
// Expected even/odd guard counts for a counter value; shared with the counter's own bench.
module guard_popcount
  import guarded_counter_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GUARD_BITS = 4
) (
  input  logic [WIDTH-1:0]      value,
  output logic [GUARD_BITS-1:0] even_cnt,
  output logic [GUARD_BITS-1:0] odd_cnt
);

  always_comb begin
    even_cnt = GUARD_BITS'(even_popcount(POP_MAX_W'(value), WIDTH));
    odd_cnt  = GUARD_BITS'(odd_popcount(POP_MAX_W'(value), WIDTH));
  end

endmodule

// File: rtl/guarded_counter_scrubber.sv
// Sequences a guarded counter: gates its increment, tracks a shadow count and
// periodically pauses it to check value and guard bits, recovering or locking on faults.
module guarded_counter_scrubber
  import guarded_counter_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned GUARD_BITS   = 4,
  parameter int unsigned SCRUB_PERIOD = 16,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic                       clk,
  input  logic                       rstn,
  guarded_counter_scrubber_if.slave  bus
);

  localparam int unsigned PERIOD_W = (SCRUB_PERIOD > 1) ? $clog2(SCRUB_PERIOD) : 1;
  localparam int unsigned RETRY_W  = $clog2(MAX_RETRY + 1);

  state_e                 state;
  logic [PERIOD_W-1:0]    period_cnt;
  logic [RETRY_W-1:0]     retry;
  logic                   stop_pending;
  logic [WIDTH-1:0]       shadow_q;
  logic                   cnt_clr_q;
  logic                   busy_q;
  logic                   err_irq_q;
  logic [ERR_COUNT_W-1:0] err_count_q;
  logic                   fatal_q;

  logic [GUARD_BITS-1:0]  exp_even;
  logic [GUARD_BITS-1:0]  exp_odd;
  logic                   check_pass;
  logic                   stop_any;
  logic                   period_last;
  logic                   cnt_en_c;

  guard_popcount #(
    .WIDTH      (WIDTH),
    .GUARD_BITS (GUARD_BITS)
  ) u_guard_popcount (
    .value    (bus.cnt_value),
    .even_cnt (exp_even),
    .odd_cnt  (exp_odd)
  );

  always_comb begin
    stop_any    = bus.stop | stop_pending;
    period_last = (period_cnt == PERIOD_W'(SCRUB_PERIOD - 1));
    cnt_en_c    = (state == ST_RUN) && !stop_any;
    check_pass  = (bus.cnt_value == shadow_q) &&
                  (bus.cnt_even  == exp_even) &&
                  (bus.cnt_odd   == exp_odd);
  end

  assign bus.cnt_en    = cnt_en_c;
  assign bus.cnt_clr   = cnt_clr_q;
  assign bus.shadow    = shadow_q;
  assign bus.busy      = busy_q;
  assign bus.err_irq   = err_irq_q;
  assign bus.err_count = err_count_q;
  assign bus.fatal     = fatal_q;

  // Sequencer; ack is applied first so a failure in the same cycle wins.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      period_cnt   <= '0;
      retry        <= '0;
      stop_pending <= 1'b0;
      shadow_q     <= '0;
      cnt_clr_q    <= 1'b0;
      busy_q       <= 1'b0;
      err_irq_q    <= 1'b0;
      err_count_q  <= '0;
      fatal_q      <= 1'b0;
    end else begin
      cnt_clr_q <= 1'b0;
      if (bus.err_ack) err_irq_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state      <= ST_RUN;
            period_cnt <= '0;
            busy_q     <= 1'b1;
          end
        end

        ST_RUN: begin
          if (stop_any) begin
            state        <= ST_IDLE;
            busy_q       <= 1'b0;
            stop_pending <= 1'b0;
          end else begin
            shadow_q   <= shadow_q + WIDTH'(1);
            period_cnt <= period_cnt + PERIOD_W'(1);
            if (period_last) state <= ST_HOLD;
          end
        end

        // One idle cycle lets the counter's lagging guard outputs settle.
        ST_HOLD: begin
          if (bus.stop) stop_pending <= 1'b1;
          state <= ST_CHECK;
        end

        ST_CHECK: begin
          if (check_pass) begin
            retry      <= '0;
            period_cnt <= '0;
            if (stop_any) begin
              state        <= ST_IDLE;
              busy_q       <= 1'b0;
              stop_pending <= 1'b0;
            end else begin
              state <= ST_RUN;
            end
          end else begin
            err_irq_q <= 1'b1;
            if (err_count_q != '1) err_count_q <= err_count_q + ERR_COUNT_W'(1);
            retry     <= retry + RETRY_W'(1);
            cnt_clr_q <= 1'b1;
            if (bus.stop) stop_pending <= 1'b1;
            state     <= ST_RECOVER;
          end
        end

        ST_RECOVER: begin
          shadow_q   <= '0;
          period_cnt <= '0;
          if (retry == RETRY_W'(MAX_RETRY)) begin
            state   <= ST_FATAL;
            fatal_q <= 1'b1;
          end else if (stop_any) begin
            state        <= ST_IDLE;
            busy_q       <= 1'b0;
            stop_pending <= 1'b0;
          end else begin
            state <= ST_RUN;
          end
        end

        ST_FATAL: begin
          state <= ST_FATAL;
        end

        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_guarded_counter_scrubber.sv
// Directed bench for guarded_counter_scrubber: two instances (MAX_RETRY 3 and 255),
// each driven by a behavioural counter with fault-injection hooks.
module tb_guarded_counter_scrubber;

  logic clk;
  logic rstn;
  int   n_total;
  int   n_bad;

  guarded_counter_scrubber_if #(.WIDTH(8), .GUARD_BITS(4)) ifa ();
  guarded_counter_scrubber_if #(.WIDTH(8), .GUARD_BITS(4)) ifb ();

  guarded_counter_scrubber #(
    .WIDTH(8), .GUARD_BITS(4), .SCRUB_PERIOD(16), .MAX_RETRY(3)
  ) dut_a (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifa)
  );

  guarded_counter_scrubber #(
    .WIDTH(8), .GUARD_BITS(4), .SCRUB_PERIOD(16), .MAX_RETRY(255)
  ) dut_b (
    .clk  (clk),
    .rstn (rstn),
    .bus  (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] pop_even(input logic [7:0] v);
    return {3'b0, v[0]} + {3'b0, v[2]} + {3'b0, v[4]} + {3'b0, v[6]};
  endfunction

  function automatic logic [3:0] pop_odd(input logic [7:0] v);
    return {3'b0, v[1]} + {3'b0, v[3]} + {3'b0, v[5]} + {3'b0, v[7]};
  endfunction

  // Behavioural counters: guard outputs lag the value by one cycle.
  logic [7:0] cnt_a, cnt_b, xor_a, xor_b;
  logic [3:0] ev_a, od_a, ev_b, od_b;
  logic       frc_ev_a;
  logic [3:0] frc_ev_val;

  always @(posedge clk) begin
    if (!rstn) begin
      cnt_a <= '0; ev_a <= '0; od_a <= '0;
      cnt_b <= '0; ev_b <= '0; od_b <= '0;
    end else begin
      if (ifa.cnt_clr)     cnt_a <= '0;
      else if (ifa.cnt_en) cnt_a <= cnt_a + 8'd1;
      if (ifb.cnt_clr)     cnt_b <= '0;
      else if (ifb.cnt_en) cnt_b <= cnt_b + 8'd1;
      ev_a <= pop_even(cnt_a); od_a <= pop_odd(cnt_a);
      ev_b <= pop_even(cnt_b); od_b <= pop_odd(cnt_b);
    end
  end

  assign ifa.cnt_value = cnt_a ^ xor_a;
  assign ifa.cnt_even  = frc_ev_a ? frc_ev_val : ev_a;
  assign ifa.cnt_odd   = od_a;
  assign ifb.cnt_value = cnt_b ^ xor_b;
  assign ifb.cnt_even  = ev_b;
  assign ifb.cnt_odd   = od_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn        = 1'b0;
    ifa.start   = 1'b0; ifa.stop = 1'b0; ifa.err_ack = 1'b0;
    ifb.start   = 1'b0; ifb.stop = 1'b0; ifb.err_ack = 1'b0;
    xor_a       = '0;   xor_b    = '0;
    frc_ev_a    = 1'b0; frc_ev_val = '0;
    step(2);
    rstn = 1'b1;
    step(1);
  endtask

  task automatic start_a();
    ifa.start = 1'b1;
    step(1);
    ifa.start = 1'b0;
  endtask

  // Advance instance B until its cnt_clr pulse; a timeout is a failed comparison.
  task automatic wait_clr_b(input int budget);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      step(1);
      if (ifb.cnt_clr) seen = 1'b1;
    end
    check("b_clr_pulse", 32'(seen), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int en_cycles;
    n_total = 0;
    n_bad   = 0;

    // Reset state and a clean first period.
    do_reset();
    rstn = 1'b0;
    step(1);
    check("rst_busy",      32'(ifa.busy),      32'd0);
    check("rst_cnt_en",    32'(ifa.cnt_en),    32'd0);
    check("rst_cnt_clr",   32'(ifa.cnt_clr),   32'd0);
    check("rst_shadow",    32'(ifa.shadow),    32'd0);
    check("rst_err_irq",   32'(ifa.err_irq),   32'd0);
    check("rst_err_count", 32'(ifa.err_count), 32'd0);
    check("rst_fatal",     32'(ifa.fatal),     32'd0);
    rstn = 1'b1;
    step(1);
    start_a();
    check("s1_busy", 32'(ifa.busy), 32'd1);
    en_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (ifa.cnt_en) en_cycles++;
      step(1);
    end
    check("s1_en_cycles",  32'(en_cycles),     32'd16);
    check("s1_hold_en",    32'(ifa.cnt_en),    32'd0);
    check("s1_shadow",     32'(ifa.shadow),    32'h10);
    step(1);
    check("s1_check_en",   32'(ifa.cnt_en),    32'd0);
    step(1);
    check("s1_next_en",    32'(ifa.cnt_en),    32'd1);
    check("s1_err_irq",    32'(ifa.err_irq),   32'd0);
    check("s1_err_count",  32'(ifa.err_count), 32'd0);

    // Value mismatch at the first check.
    do_reset();
    xor_a = 8'h01;
    start_a();
    step(17);
    check("s2_check_irq",  32'(ifa.err_irq),   32'd0);
    step(1);
    xor_a = 8'h00;
    check("s2_err_irq",    32'(ifa.err_irq),   32'd1);
    check("s2_err_count",  32'(ifa.err_count), 32'd1);
    check("s2_cnt_clr",    32'(ifa.cnt_clr),   32'd1);
    step(1);
    check("s2_clr_pulse",  32'(ifa.cnt_clr),   32'd0);
    check("s2_shadow",     32'(ifa.shadow),    32'h00);
    check("s2_resume_en",  32'(ifa.cnt_en),    32'd1);

    // Even guard forced to 3 with a correct value of 0x10.
    do_reset();
    frc_ev_a = 1'b1; frc_ev_val = 4'd3;
    start_a();
    step(18);
    frc_ev_a = 1'b0;
    check("s3_err_irq",    32'(ifa.err_irq),   32'd1);
    check("s3_err_count",  32'(ifa.err_count), 32'd1);
    check("s3_cnt_clr",    32'(ifa.cnt_clr),   32'd1);
    step(1);
    check("s3_shadow",     32'(ifa.shadow),    32'h00);
    check("s3_resume_en",  32'(ifa.cnt_en),    32'd1);

    // Three consecutive failures lock the block.
    do_reset();
    xor_a = 8'h01;
    start_a();
    step(56);
    check("s4_third_cnt",  32'(ifa.err_count), 32'd3);
    check("s4_third_clr",  32'(ifa.cnt_clr),   32'd1);
    check("s4_not_fatal",  32'(ifa.fatal),     32'd0);
    step(1);
    check("s4_fatal",      32'(ifa.fatal),     32'd1);
    check("s4_fatal_en",   32'(ifa.cnt_en),    32'd0);
    check("s4_fatal_busy", 32'(ifa.busy),      32'd1);
    ifa.start = 1'b1;
    step(1);
    ifa.start = 1'b0;
    step(2);
    check("s4_start_ign",  32'(ifa.cnt_en),    32'd0);
    check("s4_still_fat",  32'(ifa.fatal),     32'd1);
    rstn = 1'b0;
    step(1);
    rstn = 1'b1;
    check("s4_rst_fatal",  32'(ifa.fatal),     32'd0);
    check("s4_rst_count",  32'(ifa.err_count), 32'd0);
    check("s4_rst_irq",    32'(ifa.err_irq),   32'd0);
    check("s4_rst_busy",   32'(ifa.busy),      32'd0);

    // Sixteen clean periods wrap the shadow.
    do_reset();
    start_a();
    step(268);
    check("s5_shadow_f0",  32'(ifa.shadow),    32'hF0);
    step(18);
    check("s5_shadow_00",  32'(ifa.shadow),    32'h00);
    step(2);
    check("s5_wrap_en",    32'(ifa.cnt_en),    32'd1);
    check("s5_wrap_irq",   32'(ifa.err_irq),   32'd0);

    // Stop during HOLD is honoured after the check; stop in RUN gates cnt_en at once.
    do_reset();
    start_a();
    step(16);
    ifa.stop = 1'b1;
    step(1);
    ifa.stop = 1'b0;
    check("s6_check_busy", 32'(ifa.busy),      32'd1);
    step(1);
    check("s6_idle_busy",  32'(ifa.busy),      32'd0);
    check("s6_idle_en",    32'(ifa.cnt_en),    32'd0);
    check("s6_idle_shd",   32'(ifa.shadow),    32'h10);
    start_a();
    step(3);
    ifa.stop = 1'b1;
    #1;
    check("s6_run_stop",   32'(ifa.cnt_en),    32'd0);
    step(1);
    ifa.stop = 1'b0;
    check("s6_run_idle",   32'(ifa.busy),      32'd0);

    // Ack coinciding with a failure leaves the interrupt set; a lone ack clears it.
    do_reset();
    xor_a = 8'h01;
    start_a();
    step(36);
    check("s6_sticky_irq", 32'(ifa.err_irq),   32'd1);
    ifa.err_ack = 1'b1;
    step(1);
    ifa.err_ack = 1'b0;
    xor_a = 8'h00;
    check("s6_ack_set",    32'(ifa.err_irq),   32'd1);
    check("s6_ack_count",  32'(ifa.err_count), 32'd2);
    step(1);
    ifa.err_ack = 1'b1;
    step(1);
    ifa.err_ack = 1'b0;
    check("s6_ack_clear",  32'(ifa.err_irq),   32'd0);

    // err_count saturation on the MAX_RETRY=255 instance.
    do_reset();
    xor_b = 8'h01;
    ifb.start = 1'b1;
    step(1);
    ifb.start = 1'b0;
    for (int i = 0; i < 254; i++) wait_clr_b(40);
    check("s5_cnt_254",    32'(ifb.err_count), 32'd254);
    xor_b = 8'h00;
    step(19);
    check("s5_pass_cnt",   32'(ifb.err_count), 32'd254);
    check("s5_pass_en",    32'(ifb.cnt_en),    32'd1);
    xor_b = 8'h01;
    wait_clr_b(40);
    check("s5_cnt_255",    32'(ifb.err_count), 32'd255);
    wait_clr_b(40);
    check("s5_cnt_sat",    32'(ifb.err_count), 32'd255);
    check("s5_sat_fatal",  32'(ifb.fatal),     32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
